// File: rtl/vga_timing_generator.sv
// Video timing generator: one horizontal/vertical counter pair drives sync, display-enable,
// pixel coordinates and line/frame markers. All outputs are registered and describe the current
// (h_cnt, v_cnt). They are precomputed from the next-count values, so i_ce has no
// combinational path to any output.
module vga_timing_generator #(
  parameter int unsigned H_DISPLAY     = 640,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_PULSE       = 96,
  parameter int unsigned H_BACK_PORCH  = 48,
  parameter int unsigned V_DISPLAY     = 480,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_PULSE       = 2,
  parameter int unsigned V_BACK_PORCH  = 33,
  parameter bit          H_SYNC_POL    = 1'b0,
  parameter bit          V_SYNC_POL    = 1'b0,
  parameter int unsigned H_WIDTH       = 10,
  parameter int unsigned V_WIDTH       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_ce,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_h_display,
  output logic               o_v_display,
  output logic               o_display,
  output logic [H_WIDTH-1:0] o_x,
  output logic [V_WIDTH-1:0] o_y,
  output logic               o_line_end,
  output logic               o_frame_end
);

  typedef enum logic [1:0] {StFp, StPulse, StBp, StDisp} region_e;

  localparam int unsigned H_BLANK = H_FRONT_PORCH + H_PULSE + H_BACK_PORCH;
  localparam int unsigned H_TOTAL = H_BLANK + H_DISPLAY;
  localparam int unsigned V_BLANK = V_FRONT_PORCH + V_PULSE + V_BACK_PORCH;
  localparam int unsigned V_TOTAL = V_BLANK + V_DISPLAY;

  // Region start boundaries, expressed in counter width.
  localparam logic [H_WIDTH-1:0] H_PS   = H_WIDTH'(H_FRONT_PORCH);
  localparam logic [H_WIDTH-1:0] H_BS   = H_WIDTH'(H_FRONT_PORCH + H_PULSE);
  localparam logic [H_WIDTH-1:0] H_DS   = H_WIDTH'(H_BLANK);
  localparam logic [H_WIDTH-1:0] H_LAST = H_WIDTH'(H_TOTAL - 1);
  localparam logic [V_WIDTH-1:0] V_PS   = V_WIDTH'(V_FRONT_PORCH);
  localparam logic [V_WIDTH-1:0] V_BS   = V_WIDTH'(V_FRONT_PORCH + V_PULSE);
  localparam logic [V_WIDTH-1:0] V_DS   = V_WIDTH'(V_BLANK);
  localparam logic [V_WIDTH-1:0] V_LAST = V_WIDTH'(V_TOTAL - 1);

  // Region that owns count 0 once empty leading regions are skipped.
  localparam region_e H_ZERO = (H_FRONT_PORCH > 0) ? StFp :
                               (H_PULSE > 0)       ? StPulse :
                               (H_BACK_PORCH > 0)  ? StBp : StDisp;
  localparam region_e V_ZERO = (V_FRONT_PORCH > 0) ? StFp :
                               (V_PULSE > 0)       ? StPulse :
                               (V_BACK_PORCH > 0)  ? StBp : StDisp;

  if (H_TOTAL > (64'd1 << H_WIDTH)) begin : g_h_width_check
    $error("H_WIDTH too small to hold H_TOTAL-1");
  end
  if (V_TOTAL > (64'd1 << V_WIDTH)) begin : g_v_width_check
    $error("V_WIDTH too small to hold V_TOTAL-1");
  end

  // Highest boundary hit wins, so coincident boundaries skip empty regions. With no boundary hit
  // the region carries over, except out of count 0 where the reset state (FP) may stand in for
  // an empty front porch.
  function automatic region_e h_next_region(input logic [H_WIDTH-1:0] cnt_q,
                                            input logic [H_WIDTH-1:0] cnt_d,
                                            input region_e            st_q);
    region_e st;
    if (cnt_d == H_DS)       st = StDisp;
    else if (cnt_d == H_BS)  st = StBp;
    else if (cnt_d == H_PS)  st = StPulse;
    else if (cnt_d == '0)    st = H_ZERO;
    else if (cnt_q == '0)    st = H_ZERO;
    else                     st = st_q;
    return st;
  endfunction

  function automatic region_e v_next_region(input logic [V_WIDTH-1:0] cnt_q,
                                            input logic [V_WIDTH-1:0] cnt_d,
                                            input region_e            st_q);
    region_e st;
    if (cnt_d == V_DS)       st = StDisp;
    else if (cnt_d == V_BS)  st = StBp;
    else if (cnt_d == V_PS)  st = StPulse;
    else if (cnt_d == '0)    st = V_ZERO;
    else if (cnt_q == '0)    st = V_ZERO;
    else                     st = st_q;
    return st;
  endfunction

  logic [H_WIDTH-1:0] h_cnt_q, h_cnt_d;
  logic [V_WIDTH-1:0] v_cnt_q, v_cnt_d;
  region_e            h_state_q, h_state_d;
  region_e            v_state_q, v_state_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               h_disp_q, h_disp_d;
  logic               v_disp_q, v_disp_d;
  logic               disp_q, disp_d;
  logic [H_WIDTH-1:0] x_q, x_d;
  logic [V_WIDTH-1:0] y_q, y_d;
  logic               line_end_q, line_end_d;
  logic               frame_end_q, frame_end_d;
  logic               h_wrap;

  // Next counts, FSM states and the outputs that will describe them; everything holds without i_ce.
  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    h_state_d   = h_state_q;
    v_state_d   = v_state_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    h_disp_d    = h_disp_q;
    v_disp_d    = v_disp_q;
    disp_d      = disp_q;
    x_d         = x_q;
    y_d         = y_q;
    line_end_d  = line_end_q;
    frame_end_d = frame_end_q;
    h_wrap      = 1'b0;
    if (i_ce) begin
      h_wrap    = (h_cnt_q == H_LAST);
      h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
      h_state_d = h_next_region(h_cnt_q, h_cnt_d, h_state_q);
      // Vertical timing only moves on a line wrap, which keeps vsync aligned to h_cnt = 0.
      if (h_wrap) begin
        v_cnt_d   = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        v_state_d = v_next_region(v_cnt_q, v_cnt_d, v_state_q);
        vsync_d   = (v_state_d == StPulse) ? V_SYNC_POL : ~V_SYNC_POL;
        v_disp_d  = (v_state_d == StDisp);
        y_d       = (v_state_d == StDisp) ? v_cnt_d - V_DS : '0;
      end
      hsync_d     = (h_state_d == StPulse) ? H_SYNC_POL : ~H_SYNC_POL;
      h_disp_d    = (h_state_d == StDisp);
      x_d         = (h_state_d == StDisp) ? h_cnt_d - H_DS : '0;
      disp_d      = h_disp_d & v_disp_d;
      line_end_d  = (h_cnt_d == H_LAST);
      frame_end_d = (h_cnt_d == H_LAST) && (v_cnt_d == V_LAST);
    end
  end

  // Counter, FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_state_q   <= StFp;
      v_state_q   <= StFp;
      hsync_q     <= ~H_SYNC_POL;
      vsync_q     <= ~V_SYNC_POL;
      h_disp_q    <= 1'b0;
      v_disp_q    <= 1'b0;
      disp_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_state_q   <= h_state_d;
      v_state_q   <= v_state_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      h_disp_q    <= h_disp_d;
      v_disp_q    <= v_disp_d;
      disp_q      <= disp_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign o_h_display = h_disp_q;
  assign o_v_display = v_disp_q;
  assign o_display   = disp_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_line_end  = line_end_q;
  assign o_frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: three instances (small 8x6 config, default 640x480 with
// active-high syncs, and a config with empty porches) share clock and reset. Expected outputs come
// from an arithmetic model and go through a scoreboard queue; a monitor compares each cycle.
module tb_vga_timing_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ce  = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs, vs, hd, vd, de, le, fe;
    logic [9:0] x, y;
  } exp_t;

  typedef struct packed {
    exp_t [2:0] e;
  } trio_t;

  typedef struct {
    int hfp, hpl, hbp, hdi, vfp, vpl, vbp, vdi;
    bit hpol, vpol;
  } cfg_t;

  logic [2:0] hs, vs, hd, vd, dd, le, fe;
  logic [2:0] x0, y0;
  logic [9:0] x1, y1;
  logic [2:0] x2;
  logic [1:0] y2;
  exp_t       act [3];

  vga_timing_generator #(
    .H_DISPLAY(4), .H_FRONT_PORCH(1), .H_PULSE(2), .H_BACK_PORCH(1),
    .V_DISPLAY(3), .V_FRONT_PORCH(1), .V_PULSE(1), .V_BACK_PORCH(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .H_WIDTH(3), .V_WIDTH(3)
  ) u_small (
    .clk(clk), .rst(rst), .i_ce(ce[0]), .o_hsync(hs[0]), .o_vsync(vs[0]),
    .o_h_display(hd[0]), .o_v_display(vd[0]), .o_display(dd[0]), .o_x(x0), .o_y(y0),
    .o_line_end(le[0]), .o_frame_end(fe[0])
  );

  vga_timing_generator #(
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_default (
    .clk(clk), .rst(rst), .i_ce(ce[1]), .o_hsync(hs[1]), .o_vsync(vs[1]),
    .o_h_display(hd[1]), .o_v_display(vd[1]), .o_display(dd[1]), .o_x(x1), .o_y(y1),
    .o_line_end(le[1]), .o_frame_end(fe[1])
  );

  vga_timing_generator #(
    .H_DISPLAY(3), .H_FRONT_PORCH(0), .H_PULSE(2), .H_BACK_PORCH(0),
    .V_DISPLAY(2), .V_FRONT_PORCH(1), .V_PULSE(1), .V_BACK_PORCH(0),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .H_WIDTH(3), .V_WIDTH(2)
  ) u_zero (
    .clk(clk), .rst(rst), .i_ce(ce[2]), .o_hsync(hs[2]), .o_vsync(vs[2]),
    .o_h_display(hd[2]), .o_v_display(vd[2]), .o_display(dd[2]), .o_x(x2), .o_y(y2),
    .o_line_end(le[2]), .o_frame_end(fe[2])
  );

  assign act[0] = {hs[0], vs[0], hd[0], vd[0], dd[0], le[0], fe[0], 7'd0, x0, 7'd0, y0};
  assign act[1] = {hs[1], vs[1], hd[1], vd[1], dd[1], le[1], fe[1], x1, y1};
  assign act[2] = {hs[2], vs[2], hd[2], vd[2], dd[2], le[2], fe[2], 7'd0, x2, 8'd0, y2};

  cfg_t  cfg [3];
  int    mh [3];
  int    mv [3];
  bit    mfresh [3];
  trio_t sb_q [$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    nl       = 0;

  // Expected outputs for pixel (h, v); 'fresh' means no advance since reset.
  function automatic exp_t model(input cfg_t c, input int h, input int v, input bit fresh);
    exp_t e;
    int   hb = c.hfp + c.hpl + c.hbp;
    int   vb = c.vfp + c.vpl + c.vbp;
    int   ht = hb + c.hdi;
    int   vt = vb + c.vdi;
    e    = '0;
    e.hs = ~c.hpol;
    e.vs = ~c.vpol;
    if (!fresh) begin
      e.hs = (h >= c.hfp && h < c.hfp + c.hpl) ? c.hpol : ~c.hpol;
      e.vs = (v >= c.vfp && v < c.vfp + c.vpl) ? c.vpol : ~c.vpol;
      e.hd = (h >= hb);
      e.vd = (v >= vb);
      e.de = e.hd && e.vd;
      e.x  = e.hd ? 10'(h - hb) : 10'd0;
      e.y  = e.vd ? 10'(v - vb) : 10'd0;
      e.le = (h == ht - 1);
      e.fe = e.le && (v == vt - 1);
    end
    return e;
  endfunction

  task automatic check(input string name, input exp_t a, input exp_t e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s @%0t: got hs=%0b vs=%0b hd=%0b vd=%0b de=%0b le=%0b fe=%0b x=%0d y=%0d, want hs=%0b vs=%0b hd=%0b vd=%0b de=%0b le=%0b fe=%0b x=%0d y=%0d",
                  name, $time, a.hs, a.vs, a.hd, a.vd, a.de, a.le, a.fe, a.x, a.y,
                  e.hs, e.vs, e.hd, e.vd, e.de, e.le, e.fe, e.x, e.y);
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, a, e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mh[k]     = 0;
      mv[k]     = 0;
      mfresh[k] = 1'b1;
    end
  endtask

  // Drive one cycle of enables and queue the outputs expected after the following edge.
  task automatic step(input logic [2:0] c);
    trio_t t;
    int    ht, vt;
    @(negedge clk);
    ce = c;
    for (int k = 0; k < 3; k++) begin
      ht = cfg[k].hfp + cfg[k].hpl + cfg[k].hbp + cfg[k].hdi;
      vt = cfg[k].vfp + cfg[k].vpl + cfg[k].vbp + cfg[k].vdi;
      if (c[k]) begin
        mfresh[k] = 1'b0;
        mh[k]++;
        if (mh[k] == ht) begin
          mh[k] = 0;
          mv[k]++;
          if (mv[k] == vt) mv[k] = 0;
        end
      end
      t.e[k] = model(cfg[k], mh[k], mv[k], mfresh[k]);
    end
    sb_q.push_back(t);
  endtask

  // Monitor: pops one expectation per clock and measures default-config line statistics.
  initial begin
    trio_t t;
    int    lc, lhs, lhd;
    bit    seen;
    lc = 0; lhs = 0; lhd = 0; seen = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) seen = 1'b0;
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        for (int k = 0; k < 3; k++) check($sformatf("dut%0d", k), act[k], t.e[k]);
        lc++;
        lhs += int'(act[1].hs);
        lhd += int'(act[1].hd);
        if (act[1].le) begin
          if (seen) begin
            check_int("line_period", lc, 800);
            check_int("hsync_width", lhs, 96);
            check_int("h_active", lhd, 640);
            nl++;
          end
          seen = 1'b1;
          lc = 0; lhs = 0; lhd = 0;
        end
      end
    end
  end

  initial begin
    int guard;
    cfg[0] = '{1, 2, 1, 4, 1, 1, 1, 3, 1'b0, 1'b0};
    cfg[1] = '{16, 96, 48, 640, 10, 2, 33, 480, 1'b1, 1'b1};
    cfg[2] = '{0, 2, 0, 3, 1, 1, 0, 2, 1'b0, 1'b0};
    model_reset();
    rst = 1'b1;
    ce  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: small and empty-porch configs must hold reset values.
    repeat (10) step(3'b010);
    // Two full frames of the small config at full rate.
    repeat (96) step(3'b111);
    // 1-in-3 enable pattern.
    for (int i = 0; i < 144; i++) step({(i % 3 == 0), 1'b1, (i % 3 == 0)});
    // Random enables.
    repeat (400) step({1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))});

    // Walk the small config to h=5, v=4, then reset between edges.
    guard = 0;
    while (!(mh[0] == 5 && mv[0] == 4) && guard < 200) begin
      step(3'b111);
      guard++;
    end
    check_int("reach_h5_v4", mh[0] * 100 + mv[0], 504);
    @(posedge clk);
    #3;
    rst = 1'b1;
    ce  = '0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("async_rst%0d", k), act[k], model(cfg[k], 0, 0, 1'b1));
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Restart from h=0 and run long enough for full default-config lines.
    repeat (2500) step({1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))});

    repeat (3) @(posedge clk);
    #2;
    check_int("scoreboard_drained", sb_q.size(), 0);
    check_int("line_measurements", nl, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised video timing generator producing horizontal and vertical sync, display-enable and pixel coordinates from a single counter pair.
- Supersedes the standalone horizontal counter: adds vertical timing, selectable sync polarity, configurable counter widths, a pixel clock-enable and line/frame markers.
- Sits between the system clock and the pixel pipeline (frame buffer read, IPM address generator, VGA output stage).

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels
- H_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_DISPLAY, 480, active lines per frame
- V_FRONT_PORCH, 10, lines
- V_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POL, 0, active level of o_hsync (0 = active-low)
- V_SYNC_POL, 0, active level of o_vsync
- H_WIDTH, 10, counter/coordinate width, must hold H_TOTAL-1
- V_WIDTH, 10, counter/coordinate width, must hold V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_ce  in  1  pixel enable; timing advances only on clk edges with i_ce=1
- o_hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- o_vsync  out  1  vertical sync, polarity per V_SYNC_POL
- o_h_display  out  1  current pixel is in the horizontal active region
- o_v_display  out  1  current line is in the vertical active region
- o_display  out  1  o_h_display AND o_v_display
- o_x  out  H_WIDTH  active pixel column
- o_y  out  V_WIDTH  active line row
- o_line_end  out  1  current pixel is the last of its line
- o_frame_end  out  1  current pixel is the last of its frame

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Derived values:
  - H_BLANK = H_FRONT_PORCH + H_PULSE + H_BACK_PORCH
  - H_TOTAL = H_BLANK + H_DISPLAY
  - V_BLANK and V_TOTAL are defined the same way.
- Internal counters: h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1.
- Region order for both axes: front porch, then pulse, then back porch, then display.
  - Horizontal: FP is [0, H_FRONT_PORCH); PULSE is [H_FRONT_PORCH, H_FRONT_PORCH+H_PULSE); BP runs up to H_BLANK; DISPLAY is [H_BLANK, H_TOTAL).
  - Vertical regions follow the same order.
- Each axis has a 4-state FSM {FP, PULSE, BP, DISPLAY}. The state must always equal the region of its counter.
- Advance rule, on a clk edge with i_ce=1:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt = V_TOTAL-1 at the same time, v_cnt wraps to 0.
- With i_ce=0, all counters, states and outputs hold.
- All outputs are driven directly from flops, with no combinational path from i_ce. Outputs describe the current (h_cnt, v_cnt) in the same cycle; the implementation precomputes them from next-count values.
- Sync outputs:
  - o_hsync = H_SYNC_POL when h in PULSE, otherwise ~H_SYNC_POL.
  - o_vsync = V_SYNC_POL when v in PULSE, otherwise ~V_SYNC_POL.
  - o_vsync changes only coincident with h_cnt wrapping to 0.
- Coordinates:
  - o_x = h_cnt - H_BLANK while in h DISPLAY, otherwise 0.
  - o_y = v_cnt - V_BLANK while in v DISPLAY, otherwise 0.
  - Subtraction is done in H_WIDTH/V_WIDTH bits; no other wrap occurs.
- Markers:
  - o_line_end = (h_cnt == H_TOTAL-1).
  - o_frame_end = o_line_end AND (v_cnt == V_TOTAL-1).
  - Both stay asserted for as long as i_ce holds them there.
- Reset values (rst asserted, any time including mid-frame):
  - h_cnt=0, v_cnt=0, both FSMs in FP.
  - o_hsync=~H_SYNC_POL, o_vsync=~V_SYNC_POL.
  - o_h_display, o_v_display, o_display, o_line_end, o_frame_end = 0.
  - o_x=0, o_y=0.
- After reset release, the first i_ce edge moves to h_cnt=1.
- Zero-length FP, PULSE or BP is legal. The empty state is skipped and the region boundaries still hold. H_DISPLAY and V_DISPLAY must be ≥1.
- Widths: an elaboration-time check fails if H_TOTAL > 2^H_WIDTH or V_TOTAL > 2^V_WIDTH.

Test Plan:
- Reset/idle. Small config: H 1/2/1/4 (FP/PULSE/BP/DISP, H_TOTAL=8); V 1/1/1/3 (V_TOTAL=6). Hold rst, then release with i_ce=0 for 10 clks -> all outputs stay at reset values; o_hsync=1, o_vsync=1.
- Horizontal line, same config, i_ce=1:
  - o_hsync low for exactly 2 clks, starting 1 clk after the first advance.
  - o_h_display high for 4 clks with o_x = 0,1,2,3.
  - o_line_end high on the 8th pixel.
  - Period is 8 clks.
- Full frame, same config:
  - o_vsync low exactly during line 1 (pixels 8..15).
  - o_display high for 12 pixels total across lines 3..5, with o_y = 0,1,2.
  - o_frame_end pulses once per 48 pixels.
- Clock enable: drive i_ce with a 1-in-3 pattern -> output sequence identical to the i_ce=1 run, with each value held for 3 clks.
- Reset mid-operation: assert rst asynchronously (between edges) while h_cnt=5, v_cnt=4 -> outputs return to reset values immediately without waiting for a clk edge; after release, the timing restarts from h_cnt=0.
- Defaults and polarity: 640x480 with H_SYNC_POL=1, V_SYNC_POL=1 ->
  - line period 800 clks, with o_hsync high for 96 clks.
  - frame period 420000 clks, with o_vsync high for 1600 clks.
  - 307200 o_display clks per frame.
